// File: rtl/serial_add_ctrl_if.sv
// Command/result bundle for the bit-serial add/subtract controller.
// Command side drives start/sub/operands; the controller returns status and the held result.
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  // Handshake: start is taken at a rising edge only while idle or on the done cycle;
  // done is a one-cycle pulse and result/cout/ovf hold until the next done.
  modport master (output start, sub, a_in, b_in,
                  input  busy, done, result, cout, ovf);
  modport slave  (input  start, sub, a_in, b_in,
                  output busy, done, result, cout, ovf);
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell sequenced LSB first,
// one bit per clock, with a start/done handshake and held result flags.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_add_ctrl_if.slave    bus,
  output logic [1:0]          dbg_state
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the WIDTH-1 most recent sum bits; the current adder sum completes the word.
  logic [WIDTH-2:0] r_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] r_next;
  logic             last_bit;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign r_next    = {fa_s, r_sh};
  assign last_bit  = (cnt == CW'(WIDTH - 1));
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      r_sh       <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.cout   <= 1'b0;
      bus.ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            // Subtract as A + ~B + 1: invert B and preload the carry with 1.
            a_sh     <= bus.a_in;
            b_sh     <= bus.sub ? ~bus.b_in : bus.b_in;
            carry    <= bus.sub;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          r_sh  <= r_next[WIDTH-1:1];
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_co;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            // carry still holds the carry into the MSB on this edge.
            bus.result <= r_next;
            bus.cout   <= fa_co;
            bus.ovf    <= carry ^ fa_co;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            state      <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
